// File: rtl/present_tx_arbiter.sv
// Two-requester round-robin front end for a PRESENT transmitter: grants one
// requester, launches the cipher, captures the encoded frame and holds it on
// the channel until it is acknowledged. A stuck transmitter is cut off by a
// bounded WAIT phase.
module present_tx_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] msg0,
  input  logic [63:0] msg1,
  input  logic [79:0] key,
  output logic        gnt0,
  output logic        gnt1,
  output logic        tx_start,
  output logic [63:0] tx_msg,
  output logic [79:0] tx_key,
  input  logic        tx_ready,
  input  logic [83:0] tx_data,
  output logic [83:0] frame,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        frame_src,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            prio1_q, prio1_d;  // 1: req1 wins a tie
  logic            owner_q, owner_d;  // requester of the transfer in flight
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            tx_start_q, tx_start_d;
  logic [63:0]     tx_msg_q, tx_msg_d;
  logic [83:0]     frame_q, frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_src_q, frame_src_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            pick1;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      prio1_q       <= 1'b0;
      owner_q       <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_msg_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_src_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      prio1_q       <= prio1_d;
      owner_q       <= owner_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      tx_start_q    <= tx_start_d;
      tx_msg_q      <= tx_msg_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_src_q   <= frame_src_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    prio1_d       = prio1_q;
    owner_d       = owner_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    tx_start_d    = 1'b0;
    tx_msg_d      = tx_msg_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_src_d   = frame_src_q;
    timeout_d     = 1'b0;
    pick1         = req1 && (!req0 || prio1_q);

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          if (pick1) begin
            gnt1_d   = 1'b1;
            tx_msg_d = msg1;
            owner_d  = 1'b1;
            prio1_d  = 1'b0;
          end else begin
            gnt0_d   = 1'b1;
            tx_msg_d = msg0;
            owner_d  = 1'b0;
            prio1_d  = 1'b1;
          end
          tx_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        armed_d = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (armed_q && tx_ready) begin
          frame_d       = tx_data;
          frame_src_d   = owner_q;
          frame_valid_d = 1'b1;
          state_d       = StHold;
        end else begin
          // A ready seen before any low sample belongs to the previous frame.
          if (!tx_ready) armed_d = 1'b1;
          if (cnt_q == CntLast) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign tx_start    = tx_start_q;
  assign tx_msg      = tx_msg_q;
  assign tx_key      = key;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_src   = frame_src_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_present_tx_arbiter.sv
// Directed bench for present_tx_arbiter: a table of single transfers plus
// hand-written sequences for stale ready, timeout, back-pressure and reset.
module tb_present_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [63:0] msg0, msg1;
  logic [79:0] key;
  logic        gnt0, gnt1, tx_start;
  logic [63:0] tx_msg;
  logic [79:0] tx_key;
  logic        tx_ready;
  logic [83:0] tx_data;
  logic [83:0] frame;
  logic        frame_valid, frame_ack, frame_src, busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  present_tx_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1),
    .key(key), .gnt0(gnt0), .gnt1(gnt1), .tx_start(tx_start), .tx_msg(tx_msg),
    .tx_key(tx_key), .tx_ready(tx_ready), .tx_data(tx_data), .frame(frame),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_src(frame_src),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1;
    logic [63:0] m0, m1;
    int          dly;
    logic [83:0] data;
    logic        eg0, eg1;
    logic [63:0] emsg;
    logic        esrc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a granted transfer (called just after the grant) to completion.
  task automatic complete(input logic [83:0] d, input logic src);
    tx_ready = 1'b0;
    tick();
    tick();
    tx_ready = 1'b1;
    tx_data  = d;
    tick();
    chk("cmp_valid", frame_valid, 1'b1);
    chk("cmp_frame", frame, d);
    chk("cmp_src", frame_src, src);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("cmp_release", frame_valid, 1'b0);
  endtask

  initial begin
    int          n_to, at_to;
    logic        vseen;
    logic [83:0] d;

    vecs[0] = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 20,
                {20'hF00D0, 64'h0123_4567_89AB_CDEF}, 1'b1, 1'b0,
                64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3,
                {20'hF00D1, 64'hDEAD_BEEF_0000_0001}, 1'b0, 1'b1,
                64'h5555_5555_5555_5555, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1,
                {20'hF00D2, 64'h0000_0000_0000_0002}, 1'b1, 1'b0,
                64'h0000_0000_0000_0002, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'h3333_3333_3333_3333, 64'h1234_5678_9ABC_DEF0, 2,
                {20'hF00D3, 64'hCAFE_0000_0000_0003}, 1'b0, 1'b1,
                64'h1234_5678_9ABC_DEF0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h4444_4444_4444_4444, 5,
                {20'hF00D4, 64'h0F0F_0F0F_0F0F_0F0F}, 1'b1, 1'b0,
                64'h0F0F_0F0F_0F0F_0F0F, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'h7777_7777_7777_7777, 64'h8000_0000_0000_0001, 1,
                {20'hF00D5, 64'h8000_0000_0000_0001}, 1'b0, 1'b1,
                64'h8000_0000_0000_0001, 1'b1};

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; msg0 = '0; msg1 = '0;
    key = 80'h1234_5678_9ABC_DEF0_1357; tx_ready = 1'b0; tx_data = '0; frame_ack = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_pulses", {gnt0, gnt1, tx_start, frame_valid, frame_src, busy, timeout_err},
        7'b0);
    chk("rst_tx_msg", tx_msg, 64'h0);
    chk("rst_frame", frame, 84'h0);
    chk("key_pass", tx_key, 80'h1234_5678_9ABC_DEF0_1357);
    key = 80'h0;
    rst = 1'b1;
    tick();
    chk("idle_no_busy", busy, 1'b0);

    // Table of complete single transfers; round-robin order precomputed.
    for (int i = 0; i < 6; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; msg0 = vecs[i].m0; msg1 = vecs[i].m1;
      tick();
      chk("v_gnt", {gnt0, gnt1}, {vecs[i].eg0, vecs[i].eg1});
      chk("v_start", tx_start, 1'b1);
      chk("v_msg", tx_msg, vecs[i].emsg);
      chk("v_busy", busy, 1'b1);
      req0 = 1'b0; req1 = 1'b0; msg0 = ~msg0; msg1 = ~msg1; tx_ready = 1'b0;
      tick();
      chk("v_pulse_end", {gnt0, gnt1, tx_start}, 3'b0);
      chk("v_msg_held", tx_msg, vecs[i].emsg);
      repeat (vecs[i].dly) @(posedge clk);
      #1;
      chk("v_no_early", frame_valid, 1'b0);
      tx_ready = 1'b1;
      tx_data  = vecs[i].data;
      tick();
      chk("v_valid", frame_valid, 1'b1);
      chk("v_frame", frame, vecs[i].data);
      chk("v_src", frame_src, vecs[i].esrc);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("v_release", {frame_valid, busy}, 2'b0);
    end

    // Stale ready: tx_ready still high from the last frame.
    req0 = 1'b1; msg0 = 64'hFEED_FACE_0000_0006;
    tick();
    chk("st_gnt", gnt0, 1'b1);
    req0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("st_ignored", frame_valid, 1'b0);
    end
    tx_ready = 1'b0;
    tx_data  = {20'hBEEF6, 64'hFEED_FACE_0000_0006};
    tick();
    chk("st_drop", frame_valid, 1'b0);
    tx_ready = 1'b1;
    tick();
    chk("st_valid", frame_valid, 1'b1);
    chk("st_frame", frame, {20'hBEEF6, 64'hFEED_FACE_0000_0006});
    chk("st_src", frame_src, 1'b0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;

    // Timeout with req1 pending.
    req0 = 1'b1;
    tick();
    chk("to_gnt0", gnt0, 1'b1);
    req0 = 1'b0; req1 = 1'b1; msg1 = 64'h0000_0000_0000_0007; tx_ready = 1'b0;
    n_to = 0; at_to = 0; vseen = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (timeout_err) begin
        n_to++;
        at_to = k;
      end
      if (frame_valid) vseen = 1'b1;
    end
    chk("to_count", 84'(n_to), 84'd1);
    chk("to_cycle", 84'(at_to), 84'd65);
    chk("to_busy", busy, 1'b0);
    chk("to_no_valid", vseen, 1'b0);
    tick();
    chk("to_pulse_end", timeout_err, 1'b0);
    chk("to_gnt1", gnt1, 1'b1);
    chk("to_msg1", tx_msg, 64'h0000_0000_0000_0007);
    req1 = 1'b0;
    complete({20'h00007, 64'h7}, 1'b1);

    // Back-pressure: ack held off 10 cycles with req1 pending.
    req0 = 1'b1;
    tick();
    chk("bp_gnt0", gnt0, 1'b1);
    req0 = 1'b0; req1 = 1'b1; tx_ready = 1'b0;
    d = {20'hABCDE, 64'h0808_0808_0808_0808};
    tick();
    tick();
    tx_ready = 1'b1;
    tx_data  = d;
    tick();
    chk("bp_valid", frame_valid, 1'b1);
    tx_data = ~d;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_frame_stable", frame, d);
      chk("bp_valid_stable", {frame_valid, frame_src, gnt1}, 3'b100);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("bp_release", {frame_valid, gnt1}, 2'b0);
    tick();
    chk("bp_gnt1", gnt1, 1'b1);
    req1 = 1'b0;
    complete({20'h99999, 64'h9}, 1'b1);

    // Reset mid-WAIT after a req0 grant (pointer would now favour req1).
    req0 = 1'b1;
    tick();
    chk("rw_gnt0", gnt0, 1'b1);
    req0 = 1'b0; tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rw_pulses", {gnt0, gnt1, tx_start, frame_valid, frame_src, busy, timeout_err},
        7'b0);
    chk("rw_tx_msg", tx_msg, 64'h0);
    chk("rw_frame", frame, 84'h0);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rw_late_ready", {frame_valid, busy}, 2'b0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rw_prio0", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    complete({20'h12121, 64'h12}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
